// File: rtl/overture_sequencer.sv
// overture_sequencer
//   Multi-cycle instruction sequencer for the OVERTURE datapath. It fetches one
//   instruction byte per instruction from program memory over a req/ack
//   handshake. It classifies the byte by opcode bits [7:6] (immediate,
//   calculation, copy, condition). It then drives the register-file, ALU, I/O and
//   PC-load controls for exactly one retiring cycle.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   imem_req/addr        : fetch request and address (= pc)
//   imem_ack/data        : fetch data valid and instruction byte
//   rd_a_sel, rd_b_sel   : register read selects
//   wr_sel/wr_en/wr_src  : register write select, strobe, data source
//   imm                  : zero-extended 6-bit immediate
//   alu_op               : ALU function
//   cond_code/cond_true  : comparator select and result
//   pc_target            : jump target (r0 value)
//   in_valid/in_pop      : input port handshake
//   out_ready/out_push   : output port handshake
//   retire               : one-cycle pulse per completed instruction
module overture_sequencer #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [7:0]          imem_data,
  output logic [2:0]          rd_a_sel,
  output logic [2:0]          rd_b_sel,
  output logic [2:0]          wr_sel,
  output logic                wr_en,
  output logic [1:0]          wr_src,
  output logic [7:0]          imm,
  output logic [2:0]          alu_op,
  output logic [2:0]          cond_code,
  input  logic                cond_true,
  input  logic [PC_WIDTH-1:0] pc_target,
  input  logic                in_valid,
  output logic                in_pop,
  input  logic                out_ready,
  output logic                out_push,
  output logic                retire
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    IO_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] CLS_IMM  = 2'b00;
  localparam logic [1:0] CLS_CALC = 2'b01;
  localparam logic [1:0] CLS_COPY = 2'b10;
  localparam logic [1:0] CLS_COND = 2'b11;

  localparam logic [2:0] PORT_IO = 3'd6;

  state_t              state;
  state_t              next_state;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir;

  logic [1:0] cls;
  logic [2:0] src;
  logic [2:0] dst;
  logic       io_ok;
  logic       active;
  logic       done;
  logic       pc_load;

  assign cls = ir[7:6];
  assign src = ir[5:3];
  assign dst = ir[2:0];

  // A copy may only complete when every I/O port it touches is ready in the
  // same cycle; register-only copies are always ready.
  assign io_ok  = ((src != PORT_IO) || in_valid) && ((dst != PORT_IO) || out_ready);
  // Strobes are suppressed while rst is high so an abandoned instruction
  // never leaks a write, pop or push.
  assign active = ((state == EXEC) || (state == IO_WAIT)) && !rst;
  assign done   = active && ((cls != CLS_COPY) || io_ok);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= 8'h00;
    end else begin
      state <= next_state;
      if ((state == FETCH) && imem_ack) begin
        ir <= imem_data;
        pc <= pc + PC_WIDTH'(1);
      end
      // The increment already happened during fetch; a taken condition
      // replaces it with the jump target.
      if (pc_load) begin
        pc <= pc_target;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          next_state = EXEC;
        end
      end
      EXEC, IO_WAIT: begin
        if ((cls == CLS_COPY) && !io_ok) begin
          next_state = IO_WAIT;
        end else begin
          next_state = FETCH;
        end
      end
      default: next_state = FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = (state == FETCH) && !rst;
    imem_addr = pc;
    imm       = {2'b00, ir[5:0]};
    alu_op    = ir[2:0];
    cond_code = ir[2:0];
    rd_a_sel  = 3'd0;
    rd_b_sel  = 3'd0;
    wr_sel    = 3'd0;
    wr_src    = 2'd0;
    wr_en     = 1'b0;
    in_pop    = 1'b0;
    out_push  = 1'b0;
    pc_load   = 1'b0;
    retire    = done;

    unique case (cls)
      CLS_IMM: begin
        wr_sel = 3'd0;
        wr_src = 2'd0;
        wr_en  = done;
      end
      CLS_CALC: begin
        rd_a_sel = 3'd1;
        rd_b_sel = 3'd2;
        wr_sel   = 3'd3;
        wr_src   = 2'd1;
        wr_en    = done;
      end
      CLS_COPY: begin
        rd_a_sel = src;
        wr_sel   = dst;
        wr_src   = (src == PORT_IO) ? 2'd3 : 2'd2;
        // dst 6 goes to the output port and dst 7 discards the data, so only
        // r0..r5 receive a register write.
        wr_en    = done && (dst < PORT_IO);
        in_pop   = done && (src == PORT_IO);
        out_push = done && (dst == PORT_IO);
      end
      CLS_COND: begin
        pc_load = done && cond_true;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_overture_sequencer.sv
// tb_overture_sequencer
//   Self-checking bench for overture_sequencer. A stimulus process issues
//   instructions one at a time (random ack delays, random I/O stall lengths,
//   random condition results). For each instruction it pushes the expected
//   retire record: fetch address, retire cycle and controls. A monitor
//   process compares the DUT against the queue head on every cycle.
module tb_overture_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic [2:0] rd_a_sel, rd_b_sel, wr_sel;
  logic       wr_en;
  logic [1:0] wr_src;
  logic [7:0] imm;
  logic [2:0] alu_op, cond_code;
  logic       cond_true = 1'b0;
  logic [7:0] pc_target = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_pop;
  logic       out_ready = 1'b0;
  logic       out_push;
  logic       retire;

  overture_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel),
    .wr_sel(wr_sel), .wr_en(wr_en), .wr_src(wr_src),
    .imm(imm), .alu_op(alu_op),
    .cond_code(cond_code), .cond_true(cond_true), .pc_target(pc_target),
    .in_valid(in_valid), .in_pop(in_pop),
    .out_ready(out_ready), .out_push(out_push),
    .retire(retire)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] ins;
    logic [7:0] addr;
    int         rcyc;
    bit         wen;
    logic [2:0] wsel;
    logic [1:0] wsrc;
    bit         pop;
    bit         push;
  } exp_t;

  typedef struct {
    int         cyc;
    bit         req;
    logic [7:0] addr;
  } dir_t;

  exp_t exq[$];
  dir_t dq[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   prev_ret = 1'b0;
  logic [7:0] pc_m = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Instruction-level meaning of one byte, straight from the opcode classes.
  function automatic exp_t model(input logic [7:0] ins);
    exp_t e;
    e = '{ins: ins, addr: 8'h00, rcyc: 0, wen: 1'b0, wsel: 3'd0, wsrc: 2'd0,
          pop: 1'b0, push: 1'b0};
    if (ins[7:6] == 2'b00) begin
      e.wen = 1'b1; e.wsel = 3'd0; e.wsrc = 2'd0;
    end else if (ins[7:6] == 2'b01) begin
      e.wen = 1'b1; e.wsel = 3'd3; e.wsrc = 2'd1;
    end else if (ins[7:6] == 2'b10) begin
      e.pop  = (ins[5:3] == 3'd6);
      e.push = (ins[2:0] == 3'd6);
      e.wen  = (ins[2:0] <= 3'd5);
      e.wsel = ins[2:0];
      e.wsrc = e.pop ? 2'd3 : 2'd2;
    end
    return e;
  endfunction

  // Issue one instruction. Entry and exit are 1 time unit after a rising
  // edge with the DUT in FETCH. ad = cycles before ack, iw = I/O stall cycles
  // (ignored if the instruction touches no I/O port).
  task automatic run_instr(input logic [7:0] ins, input int ad, input int iw,
                           input bit ct, input logic [7:0] tgt);
    exp_t e;
    bit   is_copy, need_in, need_out;
    is_copy  = (ins[7:6] == 2'b10);
    need_in  = is_copy && (ins[5:3] == 3'd6);
    need_out = is_copy && (ins[2:0] == 3'd6);
    if (!(need_in || need_out)) iw = 0;
    e = model(ins);
    e.addr = pc_m;
    e.rcyc = cyc + ad + 1 + iw;
    exq.push_back(e);
    pc_m = pc_m + 8'd1;
    if (ins[7:6] == 2'b11 && ct) pc_m = tgt;
    for (int d = 0; d <= ad; d++) begin
      imem_ack  = (d == ad);
      imem_data = (d == ad) ? ins : 8'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      cond_true = 1'($urandom);
      pc_target = 8'($urandom);
      @(posedge clk); #1;
    end
    for (int w = 0; w <= iw; w++) begin
      imem_ack  = 1'($urandom);
      imem_data = 8'($urandom);
      cond_true = ct;
      pc_target = tgt;
      if (w == iw) begin
        in_valid  = need_in  ? 1'b1 : 1'($urandom);
        out_ready = need_out ? 1'b1 : 1'($urandom);
      end else if (need_in && need_out) begin
        in_valid  = (w % 2 == 0);
        out_ready = !in_valid;
      end else begin
        in_valid  = need_in  ? 1'b0 : 1'($urandom);
        out_ready = need_out ? 1'b0 : 1'($urandom);
      end
      @(posedge clk); #1;
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      chk("dir_req", 32'(imem_req), 32'(dq[0].req));
      if (dq[0].req) chk("dir_addr", 32'(imem_addr), 32'(dq[0].addr));
      chk("dir_strobes", 32'({retire, wr_en, in_pop, out_push}), 32'd0);
      void'(dq.pop_front());
    end else if (dq.size() > 0 && cyc > dq[0].cyc) begin
      chk("dir_timeout", 32'd1, 32'd0);
      void'(dq.pop_front());
    end

    if (mon_en) begin
      if (imem_req) begin
        if (exq.size() > 0) chk("fetch_addr", 32'(imem_addr), 32'(exq[0].addr));
        else chk("fetch_unexpected", 32'd1, 32'd0);
      end
      if (in_pop)   chk("pop_without_valid", 32'(in_valid), 32'd1);
      if (out_push) chk("push_without_ready", 32'(out_ready), 32'd1);
      if (retire) begin
        chk("retire_gap", 32'(prev_ret), 32'd0);
        if (exq.size() == 0) begin
          chk("retire_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exq.pop_front();
          chk("retire_cyc", 32'(cyc), 32'(e.rcyc));
          chk("wr_en", 32'(wr_en), 32'(e.wen));
          chk("in_pop", 32'(in_pop), 32'(e.pop));
          chk("out_push", 32'(out_push), 32'(e.push));
          if (e.wen) begin
            chk("wr_sel", 32'(wr_sel), 32'(e.wsel));
            chk("wr_src", 32'(wr_src), 32'(e.wsrc));
          end
          case (e.ins[7:6])
            2'b00: chk("imm", 32'(imm), 32'({2'b00, e.ins[5:0]}));
            2'b01: begin
              chk("alu_op", 32'(alu_op), 32'(e.ins[2:0]));
              chk("rd_a_sel", 32'(rd_a_sel), 32'd1);
              chk("rd_b_sel", 32'(rd_b_sel), 32'd2);
            end
            2'b10: chk("rd_a_sel", 32'(rd_a_sel), 32'(e.ins[5:3]));
            default: chk("cond_code", 32'(cond_code), 32'(e.ins[2:0]));
          endcase
        end
      end else begin
        chk("stray_strobe", 32'({wr_en, in_pop, out_push}), 32'd0);
      end
      if (exq.size() > 0 && cyc > exq[0].rcyc) begin
        chk("retire_timeout", 32'd1, 32'd0);
        void'(exq.pop_front());
      end
    end
    prev_ret = retire;
  end

  initial begin
    // Reset with a stray ack present: no request, no strobes, ack ignored.
    rst = 1'b1; imem_ack = 1'b1; imem_data = 8'h05; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dq.push_back('{cyc: cyc, req: 1'b0, addr: 8'h00});
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases
    run_instr(8'h05, 0, 0, 1'b0, 8'h00);
    run_instr(8'h44, 3, 0, 1'b0, 8'h00);
    run_instr(8'hB2, 0, 5, 1'b0, 8'h00);
    run_instr(8'hB6, 1, 3, 1'b0, 8'h00);
    run_instr(8'hC1, 0, 0, 1'b1, 8'hFF);
    run_instr(8'hC1, 2, 0, 1'b1, 8'h10);
    run_instr(8'hC1, 0, 0, 1'b1, 8'hFF);
    run_instr(8'hC1, 0, 0, 1'b0, 8'h10);
    run_instr(8'hB7, 0, 2, 1'b0, 8'h00);
    run_instr(8'hBE, 0, 2, 1'b0, 8'h00);
    run_instr(8'hBF, 0, 0, 1'b0, 8'h00);
    run_instr(8'h80, 1, 0, 1'b0, 8'h00);

    // Random program
    for (int n = 0; n < 300; n++) begin
      run_instr(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 8'($urandom));
    end
    run_instr(8'hC0, 0, 0, 1'b1, 8'h40);

    // Reset while stalled in IO_WAIT on a copy from the input port.
    mon_en = 1'b0;
    imem_ack = 1'b1; imem_data = 8'hB2; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b1; rst = 1'b1;
    dq.push_back('{cyc: cyc, req: 1'b0, addr: 8'h00});
    @(posedge clk); #1;
    rst = 1'b0;
    dq.push_back('{cyc: cyc, req: 1'b1, addr: 8'h00});
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
